// File: rtl/sprite_mover.sv
// Grid-aware sprite movement engine for Pac-Man and ghosts.
// Ports: frame_clk/Reset (async, high); isDefeated freezes the sprite;
// req_valid/req_dir request a heading (0 right, 1 down, 2 left, 3 up);
// blocked[d] flags a wall in direction d.
// Outputs: pos_x/pos_y position, dir heading, moving, hasMoved,
// turn_pending (a buffered request is waiting for tile alignment).
module sprite_mover #(
  parameter int X_CENTER = 304,
  parameter int Y_CENTER = 240,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int STEP     = 1,
  parameter int TILE     = 16,
  parameter int WRAP_X   = 1
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       isDefeated,
  input  logic       req_valid,
  input  logic [1:0] req_dir,
  input  logic [3:0] blocked,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] dir,
  output logic       moving,
  output logic       hasMoved,
  output logic       turn_pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int TB = $clog2(TILE);

  // Limits are checked before stepping so unsigned values never wrap.
  localparam logic [9:0] ST    = 10'(STEP);
  localparam logic [9:0] X_LO  = 10'(X_MIN);
  localparam logic [9:0] X_HI  = 10'(X_MAX + 1 - TILE);
  localparam logic [9:0] Y_LO  = 10'(Y_MIN);
  localparam logic [9:0] Y_HI  = 10'(Y_MAX + 1 - TILE);
  localparam logic [9:0] X_RL  = 10'(X_MAX + 1 - TILE - STEP);
  localparam logic [9:0] X_LL  = 10'(X_MIN + STEP);
  localparam logic [9:0] Y_DL  = 10'(Y_MAX + 1 - TILE - STEP);
  localparam logic [9:0] Y_UL  = 10'(Y_MIN + STEP);
  localparam logic       WRAP  = (WRAP_X != 0);

  state_t     state, state_nx;
  logic [1:0] pend_dir;

  logic       frozen;
  logic       aligned;
  logic       reversal;
  logic [1:0] eff_pend;
  logic       eff_tp;
  logic [1:0] next_dir;
  logic       next_moving;
  logic       next_tp;
  logic       take;
  logic       stop;
  logic [9:0] nx;
  logic [9:0] ny;

  assign frozen  = isDefeated || (state == HALT);
  assign aligned = (pos_x[TB-1:0] == '0) && (pos_y[TB-1:0] == '0);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      pos_x        <= 10'(X_CENTER);
      pos_y        <= 10'(Y_CENTER);
      dir          <= 2'd0;
      pend_dir     <= 2'd0;
      turn_pending <= 1'b0;
      hasMoved     <= 1'b0;
    end else begin
      state <= state_nx;
      if (!frozen) begin
        pos_x        <= nx;
        pos_y        <= ny;
        dir          <= next_dir;
        pend_dir     <= eff_pend;
        turn_pending <= next_tp;
        hasMoved     <= hasMoved | take;
      end
    end
  end

  always_comb begin
    // A request on this edge is seen by the decision on the same edge.
    eff_pend    = req_valid ? req_dir : pend_dir;
    eff_tp      = req_valid | turn_pending;
    reversal    = (state == MOVE) && req_valid &&
                  (req_dir == (dir ^ 2'd2));
    next_dir    = dir;
    next_moving = (state == MOVE);
    next_tp     = eff_tp;
    take        = 1'b0;
    if (reversal) begin
      next_dir    = req_dir;
      next_moving = 1'b1;
      next_tp     = 1'b0;
      take        = 1'b1;
    end else if (aligned && eff_tp && !blocked[eff_pend]) begin
      next_dir    = eff_pend;
      next_moving = 1'b1;
      next_tp     = 1'b0;
      take        = 1'b1;
    end else if (aligned && blocked[dir]) begin
      next_moving = 1'b0;
    end

    nx   = pos_x;
    ny   = pos_y;
    stop = 1'b0;
    if (next_moving) begin
      unique case (next_dir)
        2'd0: begin
          if (pos_x > X_RL) begin
            nx   = WRAP ? X_LO : X_HI;
            stop = !WRAP;
          end else begin
            nx = pos_x + ST;
          end
        end
        2'd1: begin
          if (pos_y > Y_DL) begin
            ny   = Y_HI;
            stop = 1'b1;
          end else begin
            ny = pos_y + ST;
          end
        end
        2'd2: begin
          if (pos_x < X_LL) begin
            nx   = WRAP ? X_HI : X_LO;
            stop = !WRAP;
          end else begin
            nx = pos_x - ST;
          end
        end
        2'd3: begin
          if (pos_y < Y_UL) begin
            ny   = Y_LO;
            stop = 1'b1;
          end else begin
            ny = pos_y - ST;
          end
        end
        default: ;
      endcase
    end

    if (frozen)
      state_nx = HALT;
    else if (next_moving && !stop)
      state_nx = MOVE;
    else
      state_nx = IDLE;
  end

  always_comb begin
    moving = (state == MOVE);
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: wrapping and clamping instances share stimulus
// and are compared every cycle against a tile-grid reference model.
module tb_sprite_mover;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       isDefeated = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_dir = 2'd0;
  logic [3:0] blocked = 4'd0;

  logic [9:0] wx, wy, cx, cy;
  logic [1:0] wd, cd;
  logic       wm, wh, wt, cm, ch, ct;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  always #5 frame_clk = ~frame_clk;

  sprite_mover #(.WRAP_X(1)) dut_w (
    .frame_clk(frame_clk), .Reset(Reset), .isDefeated(isDefeated),
    .req_valid(req_valid), .req_dir(req_dir), .blocked(blocked),
    .pos_x(wx), .pos_y(wy), .dir(wd), .moving(wm),
    .hasMoved(wh), .turn_pending(wt)
  );

  sprite_mover #(.WRAP_X(0)) dut_c (
    .frame_clk(frame_clk), .Reset(Reset), .isDefeated(isDefeated),
    .req_valid(req_valid), .req_dir(req_dir), .blocked(blocked),
    .pos_x(cx), .pos_y(cy), .dir(cd), .moving(cm),
    .hasMoved(ch), .turn_pending(ct)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: index 0 clamps horizontally, index 1 wraps.
  int mx[2], my[2], md[2], mp[2];
  bit mm[2], mh[2], mt[2], mhalt[2];
  int dxt[4] = '{1, 0, -1, 0};
  int dyt[4] = '{0, 1, 0, -1};

  always @(posedge frame_clk or posedge Reset) begin
    int  pend, d, nx, ny;
    bit  tp, go, al;
    for (int k = 0; k < 2; k++) begin
      if (Reset) begin
        mx[k] = 304; my[k] = 240; md[k] = 0; mp[k] = 0;
        mm[k] = 0; mh[k] = 0; mt[k] = 0; mhalt[k] = 0;
      end else if (mhalt[k] || isDefeated) begin
        mhalt[k] = 1;
        mm[k] = 0;
      end else begin
        pend = req_valid ? int'(req_dir) : mp[k];
        tp = req_valid || mt[k];
        al = (mx[k] % 16 == 0) && (my[k] % 16 == 0);
        d = md[k];
        go = mm[k];
        if (mm[k] && req_valid && int'(req_dir) == (md[k] + 2) % 4) begin
          d = req_dir; go = 1; tp = 0; mh[k] = 1;
        end else if (al && tp && !blocked[pend]) begin
          d = pend; go = 1; tp = 0; mh[k] = 1;
        end else if (al && blocked[d]) begin
          go = 0;
        end
        if (go) begin
          nx = mx[k] + dxt[d];
          ny = my[k] + dyt[d];
          if (nx > 624) begin
            nx = (k == 1) ? 0 : 624;
            if (k == 0) go = 0;
          end
          if (nx < 0) begin
            nx = (k == 1) ? 624 : 0;
            if (k == 0) go = 0;
          end
          if (ny > 464) begin ny = 464; go = 0; end
          if (ny < 0) begin ny = 0; go = 0; end
          mx[k] = nx;
          my[k] = ny;
        end
        md[k] = d; mm[k] = go; mt[k] = tp; mp[k] = pend;
      end
    end
  end

  always @(negedge frame_clk) begin
    if (cmp_en) begin
      chk("w_pos_x", wx, mx[1]);
      chk("w_pos_y", wy, my[1]);
      chk("w_dir", wd, md[1]);
      chk("w_moving", wm, mm[1]);
      chk("w_hasMoved", wh, mh[1]);
      chk("w_turn_pending", wt, mt[1]);
      chk("c_pos_x", cx, mx[0]);
      chk("c_pos_y", cy, my[0]);
      chk("c_dir", cd, md[0]);
      chk("c_moving", cm, mm[0]);
      chk("c_hasMoved", ch, mh[0]);
      chk("c_turn_pending", ct, mt[0]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge frame_clk);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    #1;
  endtask

  initial begin
    tick(1);
    Reset = 1'b0;
    cmp_en = 1;
    #1;
    chk("rst_x", wx, 304);
    chk("rst_y", wy, 240);
    chk("rst_dir", wd, 0);
    chk("rst_moving", wm, 0);
    chk("rst_hasMoved", wh, 0);
    chk("rst_pending", wt, 0);

    req_valid = 1; req_dir = 0;
    tick(1);
    chk("start_x", wx, 305);
    chk("start_moving", wm, 1);
    chk("start_hasMoved", wh, 1);

    req_dir = 1;
    tick(1);
    req_valid = 0;
    chk("buf_pending", wt, 1);
    chk("buf_x", wx, 306);
    tick(14);
    chk("align_x", wx, 320);
    chk("align_pending", wt, 1);
    tick(1);
    chk("turn_y", wy, 241);
    chk("turn_x", wx, 320);
    chk("turn_dir", wd, 1);
    chk("turn_pending_clr", wt, 0);

    req_valid = 1; req_dir = 3;
    tick(1);
    req_valid = 0;
    chk("rev_dir", wd, 3);
    chk("rev_y", wy, 240);

    blocked = 4'b1000;
    tick(1);
    chk("wall_moving", wm, 0);
    chk("wall_y", wy, 240);
    chk("wall_dir", wd, 3);

    req_valid = 1; req_dir = 0;
    tick(1);
    req_valid = 0; blocked = 4'b0000;
    chk("unblock_x", wx, 321);
    chk("unblock_dir", wd, 0);

    isDefeated = 1; req_valid = 1; req_dir = 1;
    tick(1);
    isDefeated = 0; req_dir = 2;
    chk("halt_x", wx, 321);
    chk("halt_moving", wm, 0);
    chk("halt_pending", wt, 0);
    tick(3);
    req_valid = 0;
    chk("halt_hold_x", wx, 321);
    chk("halt_hold_dir", wd, 0);

    pulse_reset();
    chk("rst2_x", wx, 304);
    chk("rst2_y", wy, 240);
    chk("rst2_hasMoved", wh, 0);

    req_valid = 1; req_dir = 2;
    tick(1);
    req_valid = 0;
    tick(303);
    chk("edge_wx", wx, 0);
    chk("edge_cx", cx, 0);
    tick(1);
    chk("wrap_x", wx, 624);
    chk("wrap_moving", wm, 1);
    chk("clamp_x", cx, 0);
    chk("clamp_moving", cm, 0);

    repeat (5000) begin
      req_valid  = ($urandom_range(0, 5) == 0);
      req_dir    = 2'($urandom_range(0, 3));
      for (int b = 0; b < 4; b++)
        blocked[b] = ($urandom_range(0, 5) == 0);
      isDefeated = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 149) == 0) begin
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
      end
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
